fetch_stream_queue: RTL and testbench
=====================================

FETCH_STREAM_QUEUE -- requirements
Module: fetch_stream_queue

Interface
REQ-001 Parameter FSQ_SIZE, default 16: entry count, power of two; FSQ_WIDTH = log2(FSQ_SIZE).
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset rst, synchronous, active-high.
REQ-004 bpu_en  in  1  prediction valid; bpu_prediction  in  PredictionResult  stream, stream_idx, stream_dir.
REQ-005 bpu_redirect  in  1  second-stage override of the previous entry; write at bpu_prediction.stream_idx.
REQ-006 bpu_last_stage  in  1; bpu_last_stage_idx  in  FSQ_WIDTH; bpu_last_stage_meta  in  PredictionMeta  final-stage metadata write.
REQ-007 stream_idx  out  FSQ_WIDTH; stream_dir  out  1  write pointer index and wrap bit to the predictor.
REQ-008 stall  out  1  queue full.
REQ-009 squash  out  1; squash_info  out  SquashInfo  backend-initiated flush to the predictor.
REQ-010 update  out  1; update_info  out  BranchUpdateInfo  commit-time training.
REQ-011 fetch_valid  out  1; fetch_stream  out  FetchStream; fetch_idx  out  FSQ_WIDTH; fetch_ready  in  1.
REQ-012 fetch_flush  out  1  kills an already-issued fetch stream.
REQ-013 be_redirect  in  1; be_redirect_idx  in  FSQ_WIDTH; be_redirect_target  in  VADDR  backend misprediction.
REQ-014 commit_valid  in  1; commit_taken  in  1; commit_target  in  VADDR  retire the head stream.

Function
REQ-015 Three pointers {dir,idx}: wr_ptr, fetch_ptr, commit_ptr; empty = fetch_ptr==wr_ptr; full = idx equal and dir differs between wr_ptr and commit_ptr.
REQ-016 stall = full, combinational; no write when full unless bpu_redirect.
REQ-017 Normal write: bpu_en & ~bpu_redirect & ~stall & ~squash -> entry[wr_ptr] <= stream; wr_ptr+1, wrapping with dir toggle.
REQ-018 bpu_redirect & bpu_en: entry[stream_idx] <= stream; wr_ptr <= stream_idx+1, discarding the younger entry.
REQ-019 bpu_redirect while fetch_ptr == stream_idx+1: fetch_ptr <= stream_idx; fetch_flush=1 the same cycle.
REQ-020 bpu_last_stage: meta[bpu_last_stage_idx] <= bpu_last_stage_meta, independent of the write path.
REQ-021 fetch_valid = ~empty; entry read combinationally at fetch_ptr; fetch_valid & fetch_ready -> fetch_ptr+1.
REQ-022 be_redirect: next cycle squash=1 for exactly one cycle, with squash_info.target_pc = be_redirect_target.
REQ-023 be_redirect: wr_ptr and fetch_ptr <= be_redirect_idx+1 (dir from wrap), and entry[be_redirect_idx] target/taken are corrected.
REQ-024 While squash=1, bpu_en is ignored.
REQ-025 Priority: be_redirect > bpu_redirect > normal write; fetch advance is suppressed in any cycle fetch_ptr is rewritten.
REQ-026 commit_valid: commit_ptr+1; the following cycle update=1, with update_info built from entry[commit_ptr], meta[commit_ptr], commit_taken and commit_target.
REQ-027 commit_valid when commit_ptr==fetch_ptr is illegal; the bench asserts on it.
REQ-028 A simultaneous write and commit on a full queue is legal; full clears next cycle.

Reset
REQ-029 rst: all pointers and dirs 0; stall, squash, update, fetch_valid and fetch_flush 0; squash_info and update_info all-zero.
REQ-030 rst mid-operation discards every entry, in-flight update and pending squash; entry and meta arrays are not cleared.

Structure
REQ-031 FSQ_SIZE, FSQ_WIDTH, and typedefs FsqEntry and FsqPtr live in the shared defines package.
REQ-032 Entry storage is one sub-module, fsq_entry_ram: write ports for predictor and redirect correction, read ports for fetch and commit.
REQ-033 Meta storage is a separate array with its own last-stage write port.

Verification
REQ-034 Reset, then 16 bpu_en writes with fetch_ready=0 -> stall=1 after the 16th; stream_idx=0, stream_dir=1.
REQ-035 Write idx3, then bpu_redirect with stream_idx=3 and new target 0x8000_0100 -> wr_ptr=4; entry3 target 0x8000_0100.
REQ-036 Entry 3 fetched, then bpu_redirect idx3 -> fetch_flush=1 that cycle; fetch_idx=3 next cycle with the new stream.
REQ-037 8 entries, be_redirect idx=2 target 0x8000_0200 -> squash=1 one cycle with target_pc=0x8000_0200; stream_idx=3; bpu_en during squash ignored.
REQ-038 commit_valid on head idx0 -> update=1 the next cycle, with update_info carrying entry0 start_addr and meta0; commit_ptr=1.
REQ-039 Full queue with a simultaneous commit and bpu_en -> write rejected; stall=0 next cycle; the retried write is accepted.

Source files
------------

// File: rtl/fetch_stream_queue_pkg.sv
// Shared types and pointer helpers for the fetch stream queue between the
// branch predictor, the fetch unit and the backend.
package fetch_stream_queue_pkg;

  localparam int FSQ_SIZE  = 16;
  localparam int FSQ_WIDTH = $clog2(FSQ_SIZE);
  localparam int VADDR_W   = 32;
  localparam int META_W    = 16;

  localparam logic [FSQ_WIDTH:0] PTR_ONE = {{FSQ_WIDTH{1'b0}}, 1'b1};

  typedef logic [VADDR_W-1:0] VADDR;

  typedef struct packed {
    VADDR start_addr;
    VADDR target;
    logic taken;
  } FetchStream;

  typedef FetchStream FsqEntry;

  typedef struct packed {
    logic                 dir;
    logic [FSQ_WIDTH-1:0] idx;
  } FsqPtr;

  typedef struct packed {
    FetchStream           stream;
    logic [FSQ_WIDTH-1:0] stream_idx;
    logic                 stream_dir;
  } PredictionResult;

  typedef struct packed {
    logic [META_W-1:0] meta;
  } PredictionMeta;

  typedef struct packed {
    VADDR                 target_pc;
    logic [FSQ_WIDTH-1:0] idx;
  } SquashInfo;

  typedef struct packed {
    VADDR          start_addr;
    VADDR          pred_target;
    logic          pred_taken;
    logic          taken;
    VADDR          target;
    PredictionMeta meta;
  } BranchUpdateInfo;

  // {dir,idx} is one counter, so a carry out of idx toggles dir.
  function automatic FsqPtr ptr_inc(FsqPtr p);
    logic [FSQ_WIDTH:0] v;
    v = {p.dir, p.idx} + PTR_ONE;
    return FsqPtr'(v);
  endfunction

  // A live index below the commit index has already wrapped past it.
  function automatic FsqPtr ptr_of_idx(logic [FSQ_WIDTH-1:0] idx, FsqPtr base);
    FsqPtr p;
    p.idx = idx;
    p.dir = (idx >= base.idx) ? base.dir : ~base.dir;
    return p;
  endfunction

endpackage

// File: rtl/fetch_stream_queue_entry_ram.sv
// Stream entry storage: one full-entry write from the predictor, one
// target/taken correction from the backend, two combinational reads.
module fsq_entry_ram
  import fetch_stream_queue_pkg::*;
(
  input  logic                 clk,
  input  logic                 pred_we,
  input  logic [FSQ_WIDTH-1:0] pred_idx,
  input  FsqEntry              pred_data,
  input  logic                 fix_we,
  input  logic [FSQ_WIDTH-1:0] fix_idx,
  input  VADDR                 fix_target,
  input  logic                 fix_taken,
  input  logic [FSQ_WIDTH-1:0] fetch_idx,
  output FsqEntry              fetch_data,
  input  logic [FSQ_WIDTH-1:0] commit_idx,
  output FsqEntry              commit_data
);

  FsqEntry mem_q [FSQ_SIZE];
  FsqEntry mem_d [FSQ_SIZE];

  // The correction is applied last so it wins on an index collision.
  always_comb begin
    mem_d = mem_q;
    if (pred_we) mem_d[pred_idx] = pred_data;
    if (fix_we) begin
      mem_d[fix_idx].target = fix_target;
      mem_d[fix_idx].taken  = fix_taken;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign fetch_data  = mem_q[fetch_idx];
  assign commit_data = mem_q[commit_idx];

endmodule

// File: rtl/fetch_stream_queue.sv
// Fetch stream queue: buffers predicted fetch streams between the predictor
// and fetch, handles predictor/backend redirects, and feeds commit training.
module fetch_stream_queue
  import fetch_stream_queue_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bpu_en,
  input  PredictionResult      bpu_prediction,
  input  logic                 bpu_redirect,
  input  logic                 bpu_last_stage,
  input  logic [FSQ_WIDTH-1:0] bpu_last_stage_idx,
  input  PredictionMeta        bpu_last_stage_meta,
  output logic [FSQ_WIDTH-1:0] stream_idx,
  output logic                 stream_dir,
  output logic                 stall,
  output logic                 squash,
  output SquashInfo            squash_info,
  output logic                 update,
  output BranchUpdateInfo      update_info,
  output logic                 fetch_valid,
  output FetchStream           fetch_stream,
  output logic [FSQ_WIDTH-1:0] fetch_idx,
  input  logic                 fetch_ready,
  output logic                 fetch_flush,
  input  logic                 be_redirect,
  input  logic [FSQ_WIDTH-1:0] be_redirect_idx,
  input  VADDR                 be_redirect_target,
  input  logic                 commit_valid,
  input  logic                 commit_taken,
  input  VADDR                 commit_target
);

  FsqPtr           wr_ptr_q, wr_ptr_d, fetch_ptr_q, fetch_ptr_d, commit_ptr_q, commit_ptr_d;
  logic            squash_q, squash_d, update_q, update_d;
  SquashInfo       squash_info_q, squash_info_d;
  BranchUpdateInfo update_info_q, update_info_d;
  PredictionMeta   meta_q [FSQ_SIZE];
  PredictionMeta   meta_d [FSQ_SIZE];

  logic    full, empty, pred_accept, bpu_fix, normal_wr, fetch_rewrite;
  FsqPtr   bpu_ptr, bpu_next, be_next;
  FsqEntry commit_entry;

  assign full        = (wr_ptr_q.idx == commit_ptr_q.idx) && (wr_ptr_q.dir != commit_ptr_q.dir);
  assign empty       = (fetch_ptr_q == wr_ptr_q);
  assign stall       = full;
  // Predictor traffic is dropped while a squash is being delivered or the backend redirects.
  assign pred_accept = bpu_en && !squash_q && !be_redirect;
  assign bpu_fix     = pred_accept && bpu_redirect;
  assign normal_wr   = pred_accept && !bpu_redirect && !full;
  assign bpu_ptr     = '{dir: bpu_prediction.stream_dir, idx: bpu_prediction.stream_idx};
  assign bpu_next    = ptr_inc(bpu_ptr);
  assign be_next     = ptr_inc(ptr_of_idx(be_redirect_idx, commit_ptr_q));
  assign fetch_flush = !rst && bpu_fix && (fetch_ptr_q == bpu_next);
  assign fetch_rewrite = be_redirect || fetch_flush;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    fetch_ptr_d   = fetch_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    squash_d      = be_redirect;
    squash_info_d = squash_info_q;
    update_d      = commit_valid;
    update_info_d = update_info_q;
    meta_d        = meta_q;

    if (be_redirect) begin
      wr_ptr_d      = be_next;
      fetch_ptr_d   = be_next;
      squash_info_d = '{target_pc: be_redirect_target, idx: be_redirect_idx};
    end else if (bpu_fix) begin
      wr_ptr_d = bpu_next;
      if (fetch_flush) fetch_ptr_d = bpu_ptr;
    end else if (normal_wr) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    if (!fetch_rewrite && !empty && fetch_ready) fetch_ptr_d = ptr_inc(fetch_ptr_q);

    if (commit_valid) begin
      commit_ptr_d  = ptr_inc(commit_ptr_q);
      update_info_d = '{start_addr:  commit_entry.start_addr,
                        pred_target: commit_entry.target,
                        pred_taken:  commit_entry.taken,
                        taken:       commit_taken,
                        target:      commit_target,
                        meta:        meta_q[commit_ptr_q.idx]};
    end

    if (bpu_last_stage) meta_d[bpu_last_stage_idx] = bpu_last_stage_meta;

    // Storage arrays keep their contents across reset; only control state clears.
    if (rst) begin
      wr_ptr_d      = '0;
      fetch_ptr_d   = '0;
      commit_ptr_d  = '0;
      squash_d      = 1'b0;
      squash_info_d = '0;
      update_d      = 1'b0;
      update_info_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q      <= wr_ptr_d;
    fetch_ptr_q   <= fetch_ptr_d;
    commit_ptr_q  <= commit_ptr_d;
    squash_q      <= squash_d;
    squash_info_q <= squash_info_d;
    update_q      <= update_d;
    update_info_q <= update_info_d;
    meta_q        <= meta_d;
  end

  fsq_entry_ram u_entry_ram (
    .clk         (clk),
    .pred_we     (normal_wr || bpu_fix),
    .pred_idx    (bpu_fix ? bpu_prediction.stream_idx : wr_ptr_q.idx),
    .pred_data   (bpu_prediction.stream),
    .fix_we      (be_redirect),
    .fix_idx     (be_redirect_idx),
    .fix_target  (be_redirect_target),
    .fix_taken   (1'b1),
    .fetch_idx   (fetch_ptr_q.idx),
    .fetch_data  (fetch_stream),
    .commit_idx  (commit_ptr_q.idx),
    .commit_data (commit_entry)
  );

  assign stream_idx  = wr_ptr_q.idx;
  assign stream_dir  = wr_ptr_q.dir;
  assign fetch_idx   = fetch_ptr_q.idx;
  assign fetch_valid = !empty;
  assign squash      = squash_q;
  assign squash_info = squash_info_q;
  assign update      = update_q;
  assign update_info = update_info_q;

endmodule

// File: tb/tb_fetch_stream_queue.sv
// Directed scenarios followed by random traffic, checked against an
// absolute-count queue model of the stream queue.
module tb_fetch_stream_queue;
  import fetch_stream_queue_pkg::*;

  typedef logic [FSQ_WIDTH-1:0] idx_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            bpu_en, bpu_redirect, bpu_last_stage, fetch_ready;
  PredictionResult bpu_prediction;
  idx_t            bpu_last_stage_idx, be_redirect_idx;
  PredictionMeta   bpu_last_stage_meta;
  logic            be_redirect, commit_valid, commit_taken;
  VADDR            be_redirect_target, commit_target;

  idx_t            stream_idx, fetch_idx;
  logic            stream_dir, stall, squash, update, fetch_valid, fetch_flush;
  SquashInfo       squash_info;
  BranchUpdateInfo update_info;
  FetchStream      fetch_stream;

  fetch_stream_queue dut (
    .clk(clk), .rst(rst),
    .bpu_en(bpu_en), .bpu_prediction(bpu_prediction), .bpu_redirect(bpu_redirect),
    .bpu_last_stage(bpu_last_stage), .bpu_last_stage_idx(bpu_last_stage_idx),
    .bpu_last_stage_meta(bpu_last_stage_meta),
    .stream_idx(stream_idx), .stream_dir(stream_dir), .stall(stall),
    .squash(squash), .squash_info(squash_info), .update(update), .update_info(update_info),
    .fetch_valid(fetch_valid), .fetch_stream(fetch_stream), .fetch_idx(fetch_idx),
    .fetch_ready(fetch_ready), .fetch_flush(fetch_flush),
    .be_redirect(be_redirect), .be_redirect_idx(be_redirect_idx),
    .be_redirect_target(be_redirect_target),
    .commit_valid(commit_valid), .commit_taken(commit_taken), .commit_target(commit_target)
  );

  // reference model: absolute stream counts, modulo only when indexing
  int              wr_c, fe_c, cm_c;
  FetchStream      ent [FSQ_SIZE];
  PredictionMeta   mta [FSQ_SIZE];
  bit              mta_ok [FSQ_SIZE];
  bit              e_squash, e_update, e_upd_meta_ok;
  VADDR            e_sq_tgt;
  BranchUpdateInfo e_upd;
  int              redir_abs, be_abs;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    bpu_en = 1'b0; bpu_redirect = 1'b0; bpu_prediction = '0;
    bpu_last_stage = 1'b0; bpu_last_stage_idx = '0; bpu_last_stage_meta = '0;
    fetch_ready = 1'b0; be_redirect = 1'b0; be_redirect_idx = '0; be_redirect_target = '0;
    commit_valid = 1'b0; commit_taken = 1'b0; commit_target = '0;
  endtask

  function automatic FetchStream rand_stream();
    FetchStream s;
    s.start_addr = $urandom;
    s.target     = $urandom;
    s.taken      = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic set_write(FetchStream s);
    bpu_en = 1'b1; bpu_redirect = 1'b0; bpu_prediction.stream = s;
  endtask

  task automatic set_redirect(int n, FetchStream s);
    bpu_en = 1'b1; bpu_redirect = 1'b1; bpu_prediction.stream = s;
    bpu_prediction.stream_idx = idx_t'(n % FSQ_SIZE);
    bpu_prediction.stream_dir = 1'((n / FSQ_SIZE) % 2);
    redir_abs = n;
  endtask

  task automatic set_be(int n, VADDR t);
    be_redirect = 1'b1; be_redirect_idx = idx_t'(n % FSQ_SIZE); be_redirect_target = t;
    be_abs = n;
  endtask

  task automatic set_commit(bit tk, VADDR t);
    commit_valid = 1'b1; commit_taken = tk; commit_target = t;
  endtask

  // one cycle: check outputs against the model, clock, advance the model
  task automatic tick();
    bit flush_exp, fv_old, rewrite;
    int cidx;
    #1;
    assert (!commit_valid || cm_c < fe_c)
      else $fatal(1, "FAIL commit_legal: commit count %0d fetch count %0d", cm_c, fe_c);
    fv_old    = (fe_c != wr_c);
    flush_exp = !rst && bpu_en && bpu_redirect && !e_squash && !be_redirect &&
                (fe_c == redir_abs + 1);
    chk("stall", 64'(stall), 64'((wr_c - cm_c) == FSQ_SIZE));
    chk("fetch_valid", 64'(fetch_valid), 64'(fv_old));
    if (fv_old) begin
      chk("fetch_idx", 64'(fetch_idx), 64'(fe_c % FSQ_SIZE));
      chk("fetch_start", 64'(fetch_stream.start_addr), 64'(ent[fe_c % FSQ_SIZE].start_addr));
      chk("fetch_target", 64'(fetch_stream.target), 64'(ent[fe_c % FSQ_SIZE].target));
      chk("fetch_taken", 64'(fetch_stream.taken), 64'(ent[fe_c % FSQ_SIZE].taken));
    end
    chk("stream_idx", 64'(stream_idx), 64'(wr_c % FSQ_SIZE));
    chk("stream_dir", 64'(stream_dir), 64'((wr_c / FSQ_SIZE) % 2));
    chk("fetch_flush", 64'(fetch_flush), 64'(flush_exp));
    chk("squash", 64'(squash), 64'(e_squash));
    if (e_squash) chk("squash_target", 64'(squash_info.target_pc), 64'(e_sq_tgt));
    chk("update", 64'(update), 64'(e_update));
    if (e_update) begin
      chk("upd_start", 64'(update_info.start_addr), 64'(e_upd.start_addr));
      chk("upd_pred_target", 64'(update_info.pred_target), 64'(e_upd.pred_target));
      chk("upd_taken", 64'(update_info.taken), 64'(e_upd.taken));
      chk("upd_target", 64'(update_info.target), 64'(e_upd.target));
      if (e_upd_meta_ok) chk("upd_meta", 64'(update_info.meta), 64'(e_upd.meta));
    end

    @(posedge clk);

    if (rst) begin
      wr_c = 0; fe_c = 0; cm_c = 0;
      e_squash = 1'b0; e_update = 1'b0; e_sq_tgt = '0; e_upd = '0;
    end else begin
      if (commit_valid) begin
        cidx = cm_c % FSQ_SIZE;
        e_upd.start_addr  = ent[cidx].start_addr;
        e_upd.pred_target = ent[cidx].target;
        e_upd.pred_taken  = ent[cidx].taken;
        e_upd.taken       = commit_taken;
        e_upd.target      = commit_target;
        e_upd.meta        = mta[cidx];
        e_upd_meta_ok     = mta_ok[cidx];
      end
      e_update = commit_valid;
      rewrite  = 1'b0;
      if (be_redirect) begin
        ent[be_abs % FSQ_SIZE].target = be_redirect_target;
        ent[be_abs % FSQ_SIZE].taken  = 1'b1;
        wr_c = be_abs + 1; fe_c = be_abs + 1; rewrite = 1'b1;
      end else if (bpu_en && !e_squash) begin
        if (bpu_redirect) begin
          ent[redir_abs % FSQ_SIZE] = bpu_prediction.stream;
          wr_c = redir_abs + 1;
          if (flush_exp) begin fe_c = redir_abs; rewrite = 1'b1; end
        end else if (wr_c - cm_c < FSQ_SIZE) begin
          ent[wr_c % FSQ_SIZE] = bpu_prediction.stream;
          wr_c++;
        end
      end
      if (!rewrite && fv_old && fetch_ready) fe_c++;
      if (commit_valid) cm_c++;
      e_squash = be_redirect;
      if (be_redirect) e_sq_tgt = be_redirect_target;
    end
    if (bpu_last_stage) begin
      mta[bpu_last_stage_idx]    = bpu_last_stage_meta;
      mta_ok[bpu_last_stage_idx] = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    FetchStream s;
    int k, r, n;
    redir_abs = -10; be_abs = 0;
    for (int i = 0; i < FSQ_SIZE; i++) mta_ok[i] = 1'b0;

    // power-on reset, model starts empty
    idle(); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wr_c = 0; fe_c = 0; cm_c = 0; e_squash = 0; e_update = 0; e_sq_tgt = '0; e_upd = '0;
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_fetch_valid", 64'(fetch_valid), 64'(0));
    chk("rst_squash", 64'(squash), 64'(0));
    chk("rst_update", 64'(update), 64'(0));
    chk("rst_stream_idx", 64'(stream_idx), 64'(0));
    chk("rst_stream_dir", 64'(stream_dir), 64'(0));
    chk("rst_squash_info_zero", 64'(squash_info == '0), 64'(1));
    chk("rst_update_info_zero", 64'(update_info == '0), 64'(1));

    // fill to full with fetch stalled
    for (int i = 0; i < FSQ_SIZE; i++) begin idle(); set_write(rand_stream()); tick(); end
    chk("fill_stall", 64'(stall), 64'(1));
    chk("fill_stream_idx", 64'(stream_idx), 64'(0));
    chk("fill_stream_dir", 64'(stream_dir), 64'(1));
    idle(); set_write(rand_stream()); tick();

    // predictor override of the previous entry
    do_reset();
    for (int i = 0; i < 4; i++) begin idle(); set_write(rand_stream()); tick(); end
    s = rand_stream(); s.target = 32'h8000_0100;
    idle(); set_redirect(3, s); tick();
    chk("ovr_stream_idx", 64'(stream_idx), 64'(4));
    k = 0;
    while (fetch_idx != 3 && k < 10) begin idle(); fetch_ready = 1'b1; tick(); k++; end
    chk("ovr_fetch_idx", 64'(fetch_idx), 64'(3));
    chk("ovr_entry3_target", 64'(fetch_stream.target), 64'(32'h8000_0100));
    idle(); fetch_ready = 1'b1; tick();

    // override of an already-fetched entry flushes fetch
    s = rand_stream(); s.target = 32'h8000_0300;
    idle(); set_redirect(3, s);
    #1;
    chk("flush_pulse", 64'(fetch_flush), 64'(1));
    tick();
    chk("flush_fetch_idx", 64'(fetch_idx), 64'(3));
    chk("flush_fetch_valid", 64'(fetch_valid), 64'(1));
    chk("flush_new_target", 64'(fetch_stream.target), 64'(32'h8000_0300));

    // backend redirect and squash
    do_reset();
    for (int i = 0; i < 8; i++) begin idle(); set_write(rand_stream()); fetch_ready = 1'b1; tick(); end
    idle(); set_be(2, 32'h8000_0200); tick();
    chk("sq_squash", 64'(squash), 64'(1));
    chk("sq_target", 64'(squash_info.target_pc), 64'(32'h8000_0200));
    chk("sq_stream_idx", 64'(stream_idx), 64'(3));
    idle(); set_write(rand_stream()); tick();
    chk("sq_one_cycle", 64'(squash), 64'(0));
    chk("sq_bpu_ignored", 64'(stream_idx), 64'(3));

    // commit produces a training update
    do_reset();
    s = rand_stream(); s.start_addr = 32'h8000_1000;
    idle(); set_write(s); tick();
    idle(); bpu_last_stage = 1'b1; bpu_last_stage_idx = '0; bpu_last_stage_meta = 16'hBEEF;
    fetch_ready = 1'b1; tick();
    idle(); set_commit(1'b1, 32'h8000_2000); tick();
    chk("cm_update", 64'(update), 64'(1));
    chk("cm_start", 64'(update_info.start_addr), 64'(32'h8000_1000));
    chk("cm_meta", 64'(update_info.meta), 64'(16'hBEEF));
    idle(); tick();

    // full queue with simultaneous commit and write
    do_reset();
    for (int i = 0; i < FSQ_SIZE; i++) begin idle(); set_write(rand_stream()); fetch_ready = 1'b1; tick(); end
    k = 0;
    while (fetch_valid && k < 40) begin idle(); fetch_ready = 1'b1; tick(); k++; end
    chk("full_drained", 64'(fetch_valid), 64'(0));
    idle(); set_commit(1'b0, $urandom); set_write(rand_stream());
    #1;
    chk("full_stall_before", 64'(stall), 64'(1));
    tick();
    chk("full_stall_cleared", 64'(stall), 64'(0));
    chk("full_write_rejected", 64'(stream_idx), 64'(0));
    idle(); set_write(rand_stream()); tick();
    chk("full_retry_accepted", 64'(stream_idx), 64'(1));
    chk("full_again", 64'(stall), 64'(1));

    // reset while a squash and an update are pending
    idle(); set_commit(1'b1, $urandom); set_be(5, 32'h8000_0500); tick();
    chk("pend_squash", 64'(squash), 64'(1));
    chk("pend_update", 64'(update), 64'(1));
    do_reset();
    chk("midrst_squash", 64'(squash), 64'(0));
    chk("midrst_update", 64'(update), 64'(0));
    chk("midrst_fetch_valid", 64'(fetch_valid), 64'(0));
    chk("midrst_stream_idx", 64'(stream_idx), 64'(0));
    chk("midrst_info_zero", 64'((squash_info == '0) && (update_info == '0)), 64'(1));

    // random traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      fetch_ready = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      if (r < 5 && fe_c > cm_c) begin
        n = cm_c + $urandom_range(0, fe_c - cm_c - 1);
        set_be(n, $urandom);
      end else if (r < 15 && wr_c > cm_c) begin
        set_redirect(wr_c - 1, rand_stream());
      end else begin
        if (r < 75) set_write(rand_stream());
        if (fe_c > cm_c && $urandom_range(0, 2) == 0)
          set_commit(1'($urandom_range(0, 1)), $urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        bpu_last_stage = 1'b1;
        bpu_last_stage_idx = idx_t'($urandom_range(0, FSQ_SIZE - 1));
        bpu_last_stage_meta = 16'($urandom);
      end
      tick();
    end
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
